updown_counter_mod: RTL and testbench
=====================================

# updown_counter_mod

Parametrised synchronous up/down counter with parallel load, programmable modulus and cascade carry. It is the generalised successor of the 8-bit cascaded counter used in the emulated datapath, for program-counter, stack-pointer and timer stages. Width and modulus are set per instance. A sticky wrap flag records every counter wrap. Stages chain through `rcoN` to `entN` with no glue logic.

## Interface
- `WIDTH`, default 8: counter width in bits; legal range 2..32.
- `MODULUS`, default 0: count modulus. 0 means 2^WIDTH. Otherwise the legal range is 2..2^WIDTH, and the terminal value is MODULUS-1.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `s`  in  2  mode select: 00 clear, 01 count down, 10 load, 11 count up.
- `enpN`  in  1  parallel count enable, active-low.
- `entN`  in  1  trickle (cascade) count enable, active-low; also gates `rcoN`.
- `d`  in  WIDTH  parallel load data.
- `q`  out  WIDTH  counter value.
- `rcoN`  out  1  ripple-carry output, active-low, combinational.
- `wrapFlag`  out  1  sticky flag: a count has wrapped since the last clear, load or reset.

## Operation
- Reset (`resetN`=0): `q`=0 and `wrapFlag`=0 immediately, without waiting for a clock edge. While reset is held, all other inputs are ignored.
- `en` = !enpN && !entN.
- Per rising clock edge, in priority order:
  - `s`=10 (load): `q` <= `d`; `wrapFlag` <= 0. Load ignores `en`.
  - `s`=00 (clear) with `en`: `q` <= 0; `wrapFlag` <= 0.
  - `s`=11 (up) with `en`:
    - If `q` >= MODULUS-1: `q` <= 0 and `wrapFlag` <= 1.
    - Otherwise `q` <= `q`+1.
  - `s`=01 (down) with `en`:
    - If `q`=0: `q` <= MODULUS-1 and `wrapFlag` <= 1.
    - Otherwise `q` <= `q`-1.
  - `en` false and `s`!=10: hold `q` and `wrapFlag`.
- Load takes `d` verbatim, even if `d` >= MODULUS. An up-count from such a value wraps to 0 and sets `wrapFlag`. A down-count from it decrements normally.
- With MODULUS=0, the terminal value is all-ones and arithmetic wraps naturally at WIDTH bits.
- `rcoN` is 1 unless `entN`=0. With `entN`=0:
  - `s`=11: `rcoN`=0 exactly when `q`=MODULUS-1 (all-ones if MODULUS=0).
  - `s`=01: `rcoN`=0 exactly when `q`=0.
  - Otherwise `rcoN`=1.
- `rcoN` does not depend on `enpN`; this is the standard trickle-carry rule.
- Cascade: tie stage k `rcoN` to stage k+1 `entN`. Share `clk`, `s` and `enpN` across stages. The upper stage then steps only on the edge where the lower stage wraps.

## Timing
- `q` and `wrapFlag` are registered and change one edge after the qualifying inputs.
- `rcoN` has zero-cycle latency: it is combinational from `q`, `s` and `entN`, and is valid in the same cycle that `q` reaches terminal.
- Reset assertion is asynchronous. Deassertion must meet recovery to `clk`; the first active edge after release operates normally.
- If reset is asserted mid-count, the count is lost. No partial update may occur on the edge coincident with reset.
- A mode change takes effect on the next edge. `rcoN` follows `s` combinationally in the same cycle.

## Configuration
- `UPDOWN_COUNTER_ASYNC_CLEAR_EN`:
  - Defined: `s`=00 also clears `q` and `wrapFlag` asynchronously, independent of `clk`, `enpN` and `entN`. The async clear source is `resetN` && (`s`!=00).
  - Undefined: clear is synchronous and gated by `en`, as described in Operation.

## Test plan
- Reset, then `s`=11, en active, WIDTH=8, MODULUS=0: 256 edges -> `q` steps 0..255; `rcoN`=0 only at `q`=255; back to `q`=0 with `wrapFlag`=1.
- MODULUS=10, load `d`=7, then up-count: `q` goes 7,8,9,0 and `wrapFlag` sets on reaching 0. Then down-count from 0 -> `q`=9.
- Load `d`=0xA5 with `enpN`=`entN`=1 -> `q`=0xA5 and `wrapFlag` cleared. With `s`=11 and `enpN`=1 -> `q` holds.
- Two 4-bit stages cascaded, up-count from 0x0F -> next edge gives 0x10; the upper stage steps only when the lower `rcoN`=0.
- Assert `resetN` low mid-cycle at `q`=0x3C -> `q`=0 before the next edge. With the macro defined, `s`=00 and enables inactive -> `q`=0 without a clock edge.
- MODULUS=10, load `d`=12, then up -> `q`=0 and `wrapFlag`=1. Load 12, then down -> `q`=11.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with parallel load, programmable modulus,
// cascade ripple-carry and sticky wrap flag. Optional async clear: UPDOWN_COUNTER_ASYNC_CLEAR_EN.
module updown_counter_mod #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [1:0]       s,
  input  logic             enpN,
  input  logic             entN,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rcoN,
  output logic             wrapFlag
);

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_UP    = 2'b11
  } mode_e;

  // Terminal value: all-ones for a full binary modulus, MODULUS-1 otherwise.
  localparam logic [WIDTH-1:0] TERM = (MODULUS == 0) ? '1 : WIDTH'(MODULUS - 64'd1);

  mode_e mode;
  logic  en;
  logic  arst_n;

  assign mode = mode_e'(s);
  assign en   = !enpN && !entN;

`ifdef UPDOWN_COUNTER_ASYNC_CLEAR_EN
  assign arst_n = resetN && (mode != MODE_CLEAR);
`else
  assign arst_n = resetN;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset branch is the only path that ignores clk.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q        <= '0;
      wrapFlag <= 1'b0;
    end else if (mode == MODE_LOAD) begin
      q        <= d;
      wrapFlag <= 1'b0;
    end else if (en) begin
      case (mode)
        MODE_CLEAR: begin
          q        <= '0;
          wrapFlag <= 1'b0;
        end
        MODE_UP: begin
          // >= so that an out-of-range loaded value also wraps to zero.
          if (q >= TERM) begin
            q        <= '0;
            wrapFlag <= 1'b1;
          end else begin
            q <= q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (q == '0) begin
            q        <= TERM;
            wrapFlag <= 1'b1;
          end else begin
            q <= q - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Trickle carry: gated by entN only, never by enpN.
  assign rcoN = !(!entN && (((mode == MODE_UP)   && (q == TERM)) ||
                            ((mode == MODE_DOWN) && (q == '0))));

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: binary and mod-10 instances plus a
// two-stage 4-bit cascade. Async-clear scenario runs when UPDOWN_COUNTER_ASYNC_CLEAR_EN is set.
module tb_updown_counter_mod;

  logic clk;
  logic resetN;
  int   errors;
  int   checks;

  // u0: WIDTH=8, MODULUS=0
  logic [1:0] s0;
  logic       enpN0, entN0;
  logic [7:0] d0, q0;
  logic       rcoN0, wrap0;

  // u1: WIDTH=8, MODULUS=10
  logic [1:0] s1;
  logic       enpN1, entN1;
  logic [7:0] d1, q1;
  logic       rcoN1, wrap1;

  // cascade: two 4-bit stages
  logic [1:0] sc;
  logic       enpNc, entNc;
  logic [3:0] dlo, dhi, qlo, qhi;
  logic       rcoN_lo, rcoN_hi, wrap_lo, wrap_hi;

  updown_counter_mod #(.WIDTH(8), .MODULUS(0)) u0 (
    .clk(clk), .resetN(resetN), .s(s0), .enpN(enpN0), .entN(entN0),
    .d(d0), .q(q0), .rcoN(rcoN0), .wrapFlag(wrap0)
  );

  updown_counter_mod #(.WIDTH(8), .MODULUS(10)) u1 (
    .clk(clk), .resetN(resetN), .s(s1), .enpN(enpN1), .entN(entN1),
    .d(d1), .q(q1), .rcoN(rcoN1), .wrapFlag(wrap1)
  );

  updown_counter_mod #(.WIDTH(4), .MODULUS(0)) u_lo (
    .clk(clk), .resetN(resetN), .s(sc), .enpN(enpNc), .entN(entNc),
    .d(dlo), .q(qlo), .rcoN(rcoN_lo), .wrapFlag(wrap_lo)
  );

  updown_counter_mod #(.WIDTH(4), .MODULUS(0)) u_hi (
    .clk(clk), .resetN(resetN), .s(sc), .enpN(enpNc), .entN(rcoN_lo),
    .d(dhi), .q(qhi), .rcoN(rcoN_hi), .wrapFlag(wrap_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    tick();
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL reset_q0: got %0h want 0", q0); end
    checks++; if (wrap0 !== 1'b0) begin errors++; $display("FAIL reset_wrap0: got %0b want 0", wrap0); end
    checks++; if (q1 !== 8'h00) begin errors++; $display("FAIL reset_q1: got %0h want 0", q1); end
    checks++; if (rcoN0 !== 1'b1) begin errors++; $display("FAIL reset_rcoN0: got %0b want 1", rcoN0); end
    checks++; if ({qhi, qlo} !== 8'h00) begin errors++; $display("FAIL reset_cascade: got %0h want 0", {qhi, qlo}); end
    resetN = 1'b1;
  endtask

  task automatic test_full_count();
    s0 = 2'b11; enpN0 = 1'b0; entN0 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      checks++; if (q0 !== 8'(i)) begin errors++; $display("FAIL count_q step %0d: got %0h want %0h", i, q0, 8'(i)); end
      checks++; if (rcoN0 !== (i == 255 ? 1'b0 : 1'b1)) begin errors++; $display("FAIL count_rcoN step %0d: got %0b", i, rcoN0); end
      checks++; if (wrap0 !== 1'b0) begin errors++; $display("FAIL count_wrap step %0d: got %0b want 0", i, wrap0); end
      tick();
    end
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL count_wrap_q: got %0h want 0", q0); end
    checks++; if (wrap0 !== 1'b1) begin errors++; $display("FAIL count_wrap_flag: got %0b want 1", wrap0); end
    enpN0 = 1'b1;
  endtask

  task automatic test_modulus();
    s1 = 2'b10; d1 = 8'd7; enpN1 = 1'b1; entN1 = 1'b1;
    tick();
    checks++; if (q1 !== 8'd7) begin errors++; $display("FAIL mod_load: got %0d want 7", q1); end
    s1 = 2'b11; enpN1 = 1'b0; entN1 = 1'b0;
    #1;
    checks++; if (rcoN1 !== 1'b1) begin errors++; $display("FAIL mod_rcoN_at7: got %0b want 1", rcoN1); end
    tick();
    checks++; if (q1 !== 8'd8) begin errors++; $display("FAIL mod_up8: got %0d want 8", q1); end
    tick();
    checks++; if (q1 !== 8'd9) begin errors++; $display("FAIL mod_up9: got %0d want 9", q1); end
    checks++; if (rcoN1 !== 1'b0) begin errors++; $display("FAIL mod_rcoN_at9: got %0b want 0", rcoN1); end
    checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL mod_wrap_before: got %0b want 0", wrap1); end
    tick();
    checks++; if (q1 !== 8'd0) begin errors++; $display("FAIL mod_wrap_q: got %0d want 0", q1); end
    checks++; if (wrap1 !== 1'b1) begin errors++; $display("FAIL mod_wrap_flag: got %0b want 1", wrap1); end
    s1 = 2'b01;
    #1;
    checks++; if (rcoN1 !== 1'b0) begin errors++; $display("FAIL mod_rcoN_down0: got %0b want 0", rcoN1); end
    tick();
    checks++; if (q1 !== 8'd9) begin errors++; $display("FAIL mod_down_wrap: got %0d want 9", q1); end
    checks++; if (wrap1 !== 1'b1) begin errors++; $display("FAIL mod_down_flag: got %0b want 1", wrap1); end
    enpN1 = 1'b1;
  endtask

  task automatic test_load_hold();
    s0 = 2'b10; d0 = 8'hA5; enpN0 = 1'b1; entN0 = 1'b1;
    tick();
    checks++; if (q0 !== 8'hA5) begin errors++; $display("FAIL load_q: got %0h want a5", q0); end
    checks++; if (wrap0 !== 1'b0) begin errors++; $display("FAIL load_wrap_clear: got %0b want 0", wrap0); end
    s0 = 2'b11; enpN0 = 1'b1; entN0 = 1'b0;
    tick();
    checks++; if (q0 !== 8'hA5) begin errors++; $display("FAIL hold_enp: got %0h want a5", q0); end
    enpN0 = 1'b0; entN0 = 1'b1;
    tick();
    checks++; if (q0 !== 8'hA5) begin errors++; $display("FAIL hold_ent: got %0h want a5", q0); end
    checks++; if (rcoN0 !== 1'b1) begin errors++; $display("FAIL rcoN_ent_inactive: got %0b want 1", rcoN0); end
    s0 = 2'b10; d0 = 8'hFF; enpN0 = 1'b1; entN0 = 1'b0;
    tick();
    s0 = 2'b11;
    #1;
    checks++; if (rcoN0 !== 1'b0) begin errors++; $display("FAIL rcoN_ignores_enp: got %0b want 0", rcoN0); end
    s0 = 2'b10; d0 = 8'hA5;
    tick();
`ifndef UPDOWN_COUNTER_ASYNC_CLEAR_EN
    s0 = 2'b00; enpN0 = 1'b1; entN0 = 1'b0;
    tick();
    checks++; if (q0 !== 8'hA5) begin errors++; $display("FAIL clear_gated: got %0h want a5", q0); end
    enpN0 = 1'b0;
    tick();
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL clear_sync: got %0h want 0", q0); end
`endif
    enpN0 = 1'b1; entN0 = 1'b1;
  endtask

  task automatic test_cascade();
    sc = 2'b10; dlo = 4'hF; dhi = 4'h0; enpNc = 1'b1; entNc = 1'b1;
    tick();
    checks++; if ({qhi, qlo} !== 8'h0F) begin errors++; $display("FAIL casc_load: got %0h want 0f", {qhi, qlo}); end
    sc = 2'b11; enpNc = 1'b0; entNc = 1'b0;
    #1;
    checks++; if (rcoN_lo !== 1'b0) begin errors++; $display("FAIL casc_lo_rcoN: got %0b want 0", rcoN_lo); end
    tick();
    checks++; if ({qhi, qlo} !== 8'h10) begin errors++; $display("FAIL casc_carry: got %0h want 10", {qhi, qlo}); end
    checks++; if (rcoN_lo !== 1'b1) begin errors++; $display("FAIL casc_lo_rcoN_after: got %0b want 1", rcoN_lo); end
    tick();
    checks++; if ({qhi, qlo} !== 8'h11) begin errors++; $display("FAIL casc_no_carry: got %0h want 11", {qhi, qlo}); end
    checks++; if (wrap_hi !== 1'b0) begin errors++; $display("FAIL casc_hi_wrap: got %0b want 0", wrap_hi); end
    checks++; if (wrap_lo !== 1'b1) begin errors++; $display("FAIL casc_lo_wrap: got %0b want 1", wrap_lo); end
    enpNc = 1'b1;
  endtask

  task automatic test_out_of_range();
    s1 = 2'b10; d1 = 8'd12; enpN1 = 1'b1; entN1 = 1'b0;
    tick();
    s1 = 2'b11; enpN1 = 1'b0;
    #1;
    checks++; if (rcoN1 !== 1'b1) begin errors++; $display("FAIL oor_rcoN: got %0b want 1", rcoN1); end
    tick();
    checks++; if (q1 !== 8'd0) begin errors++; $display("FAIL oor_up_q: got %0d want 0", q1); end
    checks++; if (wrap1 !== 1'b1) begin errors++; $display("FAIL oor_up_wrap: got %0b want 1", wrap1); end
    s1 = 2'b10; d1 = 8'd12; enpN1 = 1'b1;
    tick();
    s1 = 2'b01; enpN1 = 1'b0;
    tick();
    checks++; if (q1 !== 8'd11) begin errors++; $display("FAIL oor_down_q: got %0d want 11", q1); end
    checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL oor_down_wrap: got %0b want 0", wrap1); end
    enpN1 = 1'b1;
  endtask

  task automatic test_reset_mid();
    s0 = 2'b10; d0 = 8'h3C; enpN0 = 1'b1; entN0 = 1'b1;
    tick();
    checks++; if (q0 !== 8'h3C) begin errors++; $display("FAIL rmid_load: got %0h want 3c", q0); end
    s0 = 2'b11; enpN0 = 1'b0; entN0 = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL rmid_async: got %0h want 0", q0); end
    tick();
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL rmid_held: got %0h want 0", q0); end
    resetN = 1'b1;
    tick();
    checks++; if (q0 !== 8'h01) begin errors++; $display("FAIL rmid_release: got %0h want 1", q0); end
  endtask

`ifdef UPDOWN_COUNTER_ASYNC_CLEAR_EN
  task automatic test_async_clear();
    s0 = 2'b11; enpN0 = 1'b0; entN0 = 1'b0;
    tick();
    tick();
    checks++; if (q0 !== 8'h03) begin errors++; $display("FAIL aclr_pre: got %0h want 3", q0); end
    #2;
    enpN0 = 1'b1; entN0 = 1'b1; s0 = 2'b00;
    #1;
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL aclr_q: got %0h want 0", q0); end
    checks++; if (wrap0 !== 1'b0) begin errors++; $display("FAIL aclr_wrap: got %0b want 0", wrap0); end
  endtask
`endif

  initial begin
    errors = 0; checks = 0;
    resetN = 1'b0;
    s0 = 2'b00; enpN0 = 1'b1; entN0 = 1'b1; d0 = '0;
    s1 = 2'b00; enpN1 = 1'b1; entN1 = 1'b1; d1 = '0;
    sc = 2'b00; enpNc = 1'b1; entNc = 1'b1; dlo = '0; dhi = '0;
    test_reset();
    test_full_count();
    test_modulus();
    test_load_hold();
    test_cascade();
    test_out_of_range();
    test_reset_mid();
`ifdef UPDOWN_COUNTER_ASYNC_CLEAR_EN
    test_async_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
